// File: rtl/i2s_rx_stream.sv
// I2S / left-justified receiver, oversampled in the system clock domain.
// Delivers complete stereo pairs through a first-word-fall-through FIFO.
module i2s_rx_stream #(
  parameter int DATA_RES    = 24,
  parameter int SLOT_RES    = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        enable_i,
  input  logic                        mode_i,
  input  logic                        bck_i,
  input  logic                        lrck_i,
  input  logic                        dat_i,
  input  logic                        clr_i,
  output logic [DATA_RES-1:0]         left_o,
  output logic [DATA_RES-1:0]         right_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic                        frame_err_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(SLOT_RES + 1);
  localparam int CW = $clog2(SLOT_RES + 2);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEEK = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;

  logic [SYNC_STAGES-1:0] bck_sy;
  logic [SYNC_STAGES-1:0] lr_sy;
  logic [SYNC_STAGES-1:0] dat_sy;
  logic                   bck_d;
  logic                   lr_prev;
  logic                   bck_s;
  logic                   lr_s;
  logic                   dat_s;

  logic [1:0]          state;
  logic                mode_q;
  logic [PW-1:0]       p_q;
  logic [CW-1:0]       cnt;
  logic                have_bnd;
  logic                have_left;
  logic [DATA_RES-1:0] sreg;
  logic [DATA_RES-1:0] hold_l;
  logic                push_req;
  logic [DATA_RES-1:0] push_l;
  logic [DATA_RES-1:0] push_r;

  logic                rise;
  logic                bnd;
  logic                chan_lr;
  logic                is_left;
  logic                enter_left;
  logic                run_eff;
  logic                active;
  logic [PW-1:0]       p_cur;
  logic [DATA_RES-1:0] word;
  logic                done;
  logic                shift;
  logic                slot_bad;

  logic [2*DATA_RES-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  pop;
  logic                  push_ok;
  logic [2*DATA_RES-1:0] head;

  assign bck_s = bck_sy[SYNC_STAGES-1];
  assign lr_s  = lr_sy[SYNC_STAGES-1];
  assign dat_s = dat_sy[SYNC_STAGES-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      bck_sy  <= '0;
      lr_sy   <= '0;
      dat_sy  <= '0;
      bck_d   <= 1'b0;
      lr_prev <= 1'b0;
    end else begin
      bck_sy <= {bck_sy[SYNC_STAGES-2:0], bck_i};
      lr_sy  <= {lr_sy[SYNC_STAGES-2:0], lrck_i};
      dat_sy <= {dat_sy[SYNC_STAGES-2:0], dat_i};
      bck_d  <= bck_s;
      if (rise) lr_prev <= lr_s;
    end
  end

  // In I2S the change rise still carries a bit of the outgoing slot.
  always_comb begin
    rise       = bck_s & ~bck_d;
    bnd        = rise && (lr_s != lr_prev);
    chan_lr    = mode_q ? lr_s : lr_prev;
    is_left    = (chan_lr == mode_q);
    enter_left = bnd && (lr_s == mode_q);
    active     = enable_i && (state != IDLE);
    run_eff    = (state == RUN) || ((state == SEEK) && enter_left);
    p_cur      = (bnd && mode_q) ? '0 : p_q;
    word       = (sreg << 1) | DATA_RES'(dat_s);
    done       = rise && (p_cur == PW'(DATA_RES - 1));
    shift      = rise && (p_cur < PW'(DATA_RES));
    slot_bad   = active && bnd && have_bnd && (cnt != CW'(SLOT_RES));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state     <= IDLE;
      mode_q    <= 1'b0;
      p_q       <= '0;
      cnt       <= '0;
      have_bnd  <= 1'b0;
      have_left <= 1'b0;
      sreg      <= '0;
      hold_l    <= '0;
      push_req  <= 1'b0;
      push_l    <= '0;
      push_r    <= '0;
    end else if (!enable_i) begin
      state     <= IDLE;
      mode_q    <= mode_i;
      p_q       <= '0;
      cnt       <= '0;
      have_bnd  <= 1'b0;
      have_left <= 1'b0;
      sreg      <= '0;
      push_req  <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (state == IDLE) state <= SEEK;
      else if ((state == SEEK) && enter_left) state <= RUN;
      if (rise && (state != IDLE)) begin
        if (bnd) begin
          p_q      <= mode_q ? PW'(1) : '0;
          cnt      <= CW'(1);
          have_bnd <= 1'b1;
        end else begin
          if (p_q != PW'(SLOT_RES)) p_q <= p_q + 1'b1;
          if (cnt != CW'(SLOT_RES + 1)) cnt <= cnt + 1'b1;
        end
        if (shift) sreg <= word;
        if (done && run_eff) begin
          if (is_left) begin
            hold_l    <= word;
            have_left <= 1'b1;
          end else if (have_left) begin
            push_req  <= 1'b1;
            push_l    <= hold_l;
            push_r    <= word;
            have_left <= 1'b0;
          end
        end
        if (slot_bad) begin
          have_left <= 1'b0;
          push_req  <= 1'b0;
        end
      end
    end
  end

  assign valid_o = (level_o != '0);
  assign pop     = valid_o && ready_i;
  assign push_ok = push_req && ((level_o != (AW+1)'(FIFO_DEPTH)) || pop);
  assign head    = mem[rd_ptr];
  assign left_o  = valid_o ? head[2*DATA_RES-1:DATA_RES] : '0;
  assign right_o = valid_o ? head[DATA_RES-1:0] : '0;

  always_ff @(posedge clk_i) begin
    if (push_ok) mem[wr_ptr] <= {push_l, push_r};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_o     <= '0;
      overflow_o  <= 1'b0;
      frame_err_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      level_o <= level_o + {{AW{1'b0}}, push_ok}
                         - {{AW{1'b0}}, pop};
      if (push_req && !push_ok) overflow_o <= 1'b1;
      else if (clr_i) overflow_o <= 1'b0;
      if (slot_bad) frame_err_o <= 1'b1;
      else if (clr_i) frame_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_stream.sv
// Scoreboard bench for i2s_rx_stream: directed I2S/LJ frames,
// expected pairs queued at stimulus time, popped by a handshake monitor.
module tb_i2s_rx_stream;
  localparam int DR = 24;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          enable_i = 1'b0;
  logic          mode_i = 1'b0;
  logic          bck_i = 1'b0;
  logic          lrck_i = 1'b0;
  logic          dat_i = 1'b0;
  logic          clr_i = 1'b0;
  logic          ready_i = 1'b0;
  logic [DR-1:0] left_o;
  logic [DR-1:0] right_o;
  logic          valid_o;
  logic [2:0]    level_o;
  logic          overflow_o;
  logic          frame_err_o;

  int errors = 0;
  int checks = 0;
  logic [2*DR-1:0] exp_q [$];
  logic [2*DR-1:0] mon_e;

  always #5 clk = ~clk;

  i2s_rx_stream #(
    .DATA_RES(DR),
    .SLOT_RES(32),
    .FIFO_DEPTH(4),
    .SYNC_STAGES(2)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_ni),
    .enable_i(enable_i),
    .mode_i(mode_i),
    .bck_i(bck_i),
    .lrck_i(lrck_i),
    .dat_i(dat_i),
    .clr_i(clr_i),
    .left_o(left_o),
    .right_o(right_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .level_o(level_o),
    .overflow_o(overflow_o),
    .frame_err_o(frame_err_o)
  );

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic slot_bit(logic [DR-1:0] w, int i, logic lj);
    int p;
    p = lj ? i : i - 1;
    return (p >= 0 && p < DR) ? w[DR-1-p] : 1'b0;
  endfunction

  task automatic send_bit(logic lr, logic d);
    bck_i = 1'b0;
    lrck_i = lr;
    dat_i = d;
    tick(8);
    bck_i = 1'b1;
    tick(8);
  endtask

  task automatic send_slot(logic lr, logic [DR-1:0] w, int n, logic lj);
    for (int i = 0; i < n; i++) send_bit(lr, slot_bit(w, i, lj));
  endtask

  // Left slot uses lrck = lj (I2S left low, LJ left high).
  task automatic send_frame(logic [DR-1:0] l, logic [DR-1:0] r,
                            logic lj, logic push, int lbits);
    if (push) exp_q.push_back({l, r});
    send_slot(lj, l, lbits, lj);
    send_slot(!lj, r, 32, lj);
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (level_o != 3'd0 && n < 100) begin
      tick();
      n++;
    end
    check(name, 32'(level_o), 32'd0);
    check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clr();
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    tick();
  endtask

  always @(negedge clk) begin
    if (rst_ni && valid_o && ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %h/%h expected none",
                 left_o, right_o);
      end else begin
        mon_e = exp_q.pop_front();
        if ({left_o, right_o} !== mon_e) begin
          errors++;
          $display("FAIL pop_pair: got %h/%h expected %h/%h",
                   left_o, right_o, mon_e[2*DR-1:DR], mon_e[DR-1:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_left", 32'(left_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);
    rst_ni = 1'b1;
    tick(2);

    // 1: I2S, partial first frame then one good pair
    ready_i = 1'b1;
    enable_i = 1'b1;
    tick(4);
    send_slot(1'b0, 24'h5A5A5A, 10, 1'b0);
    send_slot(1'b1, 24'h3C3C3C, 32, 1'b0);
    send_frame(24'h123456, 24'hABCDEF, 1'b0, 1'b1, 32);
    tick(4);
    wait_drain("i2s_drain");

    // 2: LJ, mode flip while enabled must be ignored
    enable_i = 1'b0;
    mode_i = 1'b1;
    tick(3);
    enable_i = 1'b1;
    tick(2);
    mode_i = 1'b0;
    send_slot(1'b0, 24'h000000, 32, 1'b1);
    send_frame(24'h800001, 24'h7FFFFE, 1'b1, 1'b1, 32);
    tick(4);
    wait_drain("lj_drain");
    check("lj_ferr", 32'(frame_err_o), 32'd0);

    // back to I2S through IDLE
    enable_i = 1'b0;
    tick(3);
    enable_i = 1'b1;
    tick(2);
    send_slot(1'b1, 24'h000000, 32, 1'b0);

    // 3: backpressure, six frames into a depth-4 FIFO
    ready_i = 1'b0;
    for (int f = 1; f <= 6; f++)
      send_frame(24'h100000 + 24'(f), 24'h200000 + 24'(f),
                 1'b0, f <= 4, 32);
    check("bp_level", 32'(level_o), 32'd4);
    check("bp_ovf", 32'(overflow_o), 32'd1);
    ready_i = 1'b1;
    wait_drain("bp_drain");
    pulse_clr();
    check("bp_ovf_clr", 32'(overflow_o), 32'd0);
    check("bp_ferr", 32'(frame_err_o), 32'd0);

    // 4: short 28-bit left slot drops its frame
    send_frame(24'h0A0A0A, 24'h0B0B0B, 1'b0, 1'b0, 28);
    check("short_ferr", 32'(frame_err_o), 32'd1);
    send_frame(24'h000001, 24'h000002, 1'b0, 1'b1, 32);
    tick(4);
    wait_drain("short_drain");
    pulse_clr();
    check("short_ferr_clr", 32'(frame_err_o), 32'd0);

    // 5: reset in the middle of a left slot
    ready_i = 1'b0;
    send_frame(24'h111111, 24'h222222, 1'b0, 1'b1, 32);
    check("pre_rst_level", 32'(level_o), 32'd1);
    send_slot(1'b0, 24'hFFFFFF, 12, 1'b0);
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    void'(exp_q.pop_back());
    check("mid_rst_valid", 32'(valid_o), 32'd0);
    check("mid_rst_level", 32'(level_o), 32'd0);
    check("mid_rst_left", 32'(left_o), 32'd0);
    check("mid_rst_right", 32'(right_o), 32'd0);
    check("mid_rst_flags", 32'({overflow_o, frame_err_o}), 32'd0);
    ready_i = 1'b1;
    for (int i = 12; i < 32; i++) send_bit(1'b0, 1'b1);
    send_slot(1'b1, 24'h000000, 32, 1'b0);
    send_frame(24'h333333, 24'h444444, 1'b0, 1'b1, 32);
    tick(4);
    wait_drain("rst_drain");

    // 6: FIFO full, pop lands in the same cycle as a push
    ready_i = 1'b0;
    for (int g = 1; g <= 4; g++)
      send_frame(24'hC00000 + 24'(g), 24'hD00000 + 24'(g),
                 1'b0, 1'b1, 32);
    check("full_level", 32'(level_o), 32'd4);
    exp_q.push_back({24'hC00005, 24'hD00005});
    send_slot(1'b0, 24'hC00005, 32, 1'b0);
    for (int i = 0; i < 24; i++)
      send_bit(1'b1, slot_bit(24'hD00005, i, 1'b0));
    bck_i = 1'b0;
    dat_i = slot_bit(24'hD00005, 24, 1'b0);
    tick(8);
    bck_i = 1'b1;
    tick(3);
    ready_i = 1'b1;
    tick();
    ready_i = 1'b0;
    check("pp_level", 32'(level_o), 32'd4);
    check("pp_ovf", 32'(overflow_o), 32'd0);
    tick(4);
    for (int i = 25; i < 32; i++) send_bit(1'b1, 1'b0);
    check("pp_ovf_after", 32'(overflow_o), 32'd0);
    ready_i = 1'b1;
    wait_drain("pp_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx_stream.md
# i2s_rx_stream

Parametrised, system-clocked successor of the bit-clocked I2S receiver. It oversamples `bck_i`, `lrck_i` and `dat_i` in the `clk_i` domain and supports Philips I2S and left-justified framing. It checks slot length and delivers complete stereo pairs through a first-word-fall-through FIFO with a valid/ready handshake. It sits between the ADC pins and the tuner's sample-processing pipeline.

## Interface
Parameters:
- `DATA_RES`, 24: captured bits per channel, MSB first; 1 ≤ DATA_RES ≤ SLOT_RES.
- `SLOT_RES`, 32: expected `bck` periods per channel slot.
- `FIFO_DEPTH`, 4: stereo-pair entries; power of 2, ≥ 2.
- `SYNC_STAGES`, 2: synchroniser flops per pin input; ≥ 2.

Ports:
- `clk_i`  in  1  system clock. Must run at ≥ 4× bck, with bck high and low each lasting ≥ 2 clk periods.
- `rst_ni`  in  1  synchronous, active-low reset.
- `enable_i`  in  1  capture enable.
- `mode_i`  in  1  0 = Philips I2S, 1 = left-justified. Sampled only while `enable_i` = 0.
- `bck_i`, `lrck_i`, `dat_i`  in  1 each  asynchronous I2S pins.
- `clr_i`  in  1  clears the sticky flags.
- `left_o`, `right_o`  out  DATA_RES each  FIFO head pair.
- `valid_o`  out  1  FIFO not empty.
- `ready_i`  in  1  consumer accepts the head pair.
- `level_o`  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- `overflow_o`  out  1  sticky; a pair was dropped because the FIFO was full.
- `frame_err_o`  out  1  sticky; a slot-length violation occurred.

## Operation
- **Synchronisation.** Each pin passes through SYNC_STAGES flops. `rise` = synchronised bck is 1 now and was 0 on the previous cycle. All capture logic advances only on `rise`. lrck and dat are taken from their synchronised copies in the same cycle.
- **Slot boundary.** An lrck change is detected at a `rise` where the synchronised lrck differs from its stored previous value.
- **Channel select.** The slot is the left channel when lrck equals `mode_i`: I2S left = lrck 0, LJ left = lrck 1.
- **Slot position p.**
  - LJ mode: p = 0 at the change rise.
  - I2S mode: p = 0 at the first rise after the change.
  - p increments on every rise and saturates at SLOT_RES.
  - Bits with p < DATA_RES shift into the shift register MSB-first. Bits at later positions are ignored.
- **Word completion.** At p = DATA_RES−1 the word is complete.
  - A completed left word is stored in the left holding register and sets `have_left`.
  - A completed right word with `have_left` = 1 pushes {left, right} into the FIFO and clears `have_left`.
- **Slot length check.** At each boundary, let N = number of rises from the previous boundary.
  - If N ≠ SLOT_RES and at least one full boundary-to-boundary slot has been seen since start, set `frame_err_o` and clear `have_left`, dropping the pair.
  - A word not completed in a short slot is discarded.
- **Start-up state machine.** States: IDLE, SEEK, RUN.
  - IDLE → SEEK when `enable_i` = 1.
  - SEEK → RUN on the first boundary entering a left slot. Nothing is captured in SEEK.
  - Any state → IDLE when `enable_i` = 0. This clears p, the shift register, `have_left` and the slot counter. FIFO contents are kept and keep draining.
- **FIFO.**
  - Pop when `valid_o` & `ready_i`.
  - A push is accepted if level < FIFO_DEPTH or a pop occurs in the same cycle.
  - Otherwise the pair is dropped and `overflow_o` is set.
  - Outputs show the head entry combinationally from storage.
- **Sticky flags.** `clr_i` clears both. A set event in the same cycle wins over `clr_i`.

## Timing
- **Reset values.** `rst_ni` = 0 at a clk edge gives, on the next cycle:
  - `left_o` = `right_o` = 0, `valid_o` = 0, `level_o` = 0, both flags 0.
  - State IDLE, FIFO pointers 0, synchroniser flops 0.
  - This applies identically when reset arrives mid-slot.
- **Rise latency.** If edge k is the first `clk_i` edge that samples `bck_i` high, `rise` is asserted during the cycle after edge k+SYNC_STAGES−1. The bit is shifted in at edge k+SYNC_STAGES.
- **Push latency.** For the right LSB (p = DATA_RES−1), the FIFO write occurs at edge k+SYNC_STAGES+1. `valid_o` and `level_o` update at that same edge when the FIFO was empty.
- **Throughput.** One push per frame and one pop per clk. No bubbles on the handshake.
- **Boundary cases.**
  - Push and pop in the same cycle at full: level unchanged, no overflow.
  - Push and pop in the same cycle at level 1: level stays 1 and the head advances.
  - Pointer wrap-around at FIFO_DEPTH is seamless.
- **Mode change.** A change of `mode_i` while enabled is ignored until the next pass through IDLE.

## Test plan
DATA_RES = 24, SLOT_RES = 32, FIFO_DEPTH = 4, clk = 16× bck for all scenarios.
1. **I2S mode.** Partial first frame, then left = 0x123456 and right = 0xABCDEF. Response: exactly one pair, `left_o` = 0x123456, `right_o` = 0xABCDEF; the partial frame is never pushed.
2. **LJ mode.** Left in the lrck-high slot, MSB on the change rise, left = 0x800001 and right = 0x7FFFFE. Response: pair popped with exactly those values.
3. **Backpressure.** `ready_i` = 0 for 6 frames. Response: `level_o` = 4, `overflow_o` = 1; pops return frames 1–4 in order; `clr_i` pulse gives `overflow_o` = 0.
4. **Short slot.** One slot of 28 bck periods. Response: `frame_err_o` = 1, that frame is not pushed, and the next well-formed frame 0x000001/0x000002 is pushed.
5. **Reset mid-slot.** `rst_ni` = 0 for 1 cycle in the middle of a left slot. Response: all outputs 0 on the next cycle; the first pushed pair is the next complete frame.
6. **Full with simultaneous push/pop.** FIFO full, `ready_i` = 1 in the cycle of a push. Response: `level_o` stays 4, `overflow_o` stays 0, ordering preserved.
